// File: rtl/blink_pkg.sv
// blink_pkg: shared types and helpers for the blink_array LED driver.
//   mode_e   - per-channel operating mode (OFF, ON, BLINK, PWM)
//   ch_width - width of the channel-select field, never narrower than 1 bit
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// blink_prescaler: shared time base for the LED channels.
//   clk, rst_n - clock, asynchronous active-low reset
//   sync       - clears the count; the next tick follows PRESCALE cycles later
//   tick       - registered one-cycle pulse each time the count wraps
module blink_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;

    // With PRESCALE=1 the count is pinned at 0 == LAST, so tick stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (sync) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/blink_array.sv
// blink_array: multi-channel LED driver (OFF / ON / BLINK / PWM per channel).
//   clk, rst_n   - clock, asynchronous active-low reset
//   cfg_we       - single-cycle write of {cfg_mode, cfg_period, cfg_duty}
//                  into channel cfg_ch (out-of-range channels ignored)
//   sync         - realigns the prescaler and every channel phase
//   tick         - prescaler pulse, exported for observability
//   led[N_CH-1:0]- registered LED outputs
// Build option: define BLINK_ARRAY_PWM_EN to include PWM mode and the duty
// registers; without it mode 3 acts as OFF and cfg_duty is not stored.
module blink_array
    import blink_pkg::*;
#(
    parameter  int PRESCALE = 50000,
    parameter  int N_CH     = 4,
    parameter  int PER_W    = 8,
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [PER_W-1:0] cfg_period,
    input  logic [PER_W-1:0] cfg_duty,
    input  logic             sync,
    output logic             tick,
    output logic [N_CH-1:0]  led
);

    blink_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .sync  (sync),
        .tick  (tick)
    );

`ifndef BLINK_ARRAY_PWM_EN
    logic unused_duty;
    assign unused_duty = ^cfg_duty;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mode_e            mode_q;
        logic [PER_W-1:0] per_q, cnt_q, cnt_nx, last;
        logic             led_q, sel, wrap;

        // Only an exact full-width match selects, so indices >= N_CH hit nothing.
        assign sel    = cfg_we && (cfg_ch == CH_W'(i));
        // Period 0 behaves as period 1.
        assign last   = (per_q == '0) ? '0 : per_q - 1'b1;
        assign wrap   = (cnt_q == last);
        assign cnt_nx = wrap ? '0 : cnt_q + 1'b1;

`ifdef BLINK_ARRAY_PWM_EN
        logic [PER_W-1:0] duty_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   duty_q <= '0;
            else if (sel) duty_q <= cfg_duty;
        end
`endif

        // Priority: write > sync > tick. A write in a sync cycle still loads,
        // and a write in a tick cycle swallows that tick for this channel.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q <= MODE_OFF;
                per_q  <= '0;
                cnt_q  <= '0;
                led_q  <= 1'b0;
            end else if (sel) begin
                mode_q <= mode_e'(cfg_mode);
                per_q  <= cfg_period;
                cnt_q  <= '0;
                case (mode_e'(cfg_mode))
                    MODE_ON:  led_q <= 1'b1;
`ifdef BLINK_ARRAY_PWM_EN
                    MODE_PWM: led_q <= (cfg_duty != '0);
`endif
                    default:  led_q <= 1'b0;
                endcase
            end else if (sync) begin
                cnt_q <= '0;
                case (mode_q)
                    MODE_ON:  led_q <= 1'b1;
`ifdef BLINK_ARRAY_PWM_EN
                    MODE_PWM: led_q <= (duty_q != '0);
`endif
                    default:  led_q <= 1'b0;
                endcase
            end else if (tick) begin
                case (mode_q)
                    MODE_BLINK: begin
                        cnt_q <= cnt_nx;
                        if (wrap) led_q <= ~led_q;
                    end
`ifdef BLINK_ARRAY_PWM_EN
                    MODE_PWM: begin
                        cnt_q <= cnt_nx;
                        led_q <= (cnt_nx < duty_q);
                    end
`endif
                    default: ;  // OFF/ON: cnt stays 0, led already settled
                endcase
            end
        end

        assign led[i] = led_q;
    end

endmodule

// File: tb/tb_blink_array.sv
// tb_blink_array: directed, table-driven bench for blink_array with
// PRESCALE=4, N_CH=4, PER_W=8. A second instance with N_CH=5 gives a 3-bit
// channel field so that out-of-range channel indices can be driven.
// Expected LED values depend on whether BLINK_ARRAY_PWM_EN is defined.
module tb_blink_array;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_period = '0;
    logic [7:0] cfg_duty = '0;
    logic       sync = 1'b0;
    logic       tick;
    logic [3:0] led;

    logic       we5 = 1'b0;
    logic [2:0] ch5 = '0;
    logic [1:0] mode5 = '0;
    logic [7:0] per5 = '0;
    logic [7:0] duty5 = '0;
    logic       tick5;
    logic [4:0] led5;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    blink_array #(.PRESCALE(4), .N_CH(4), .PER_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .sync(sync), .tick(tick), .led(led)
    );

    blink_array #(.PRESCALE(4), .N_CH(5), .PER_W(8)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .cfg_we(we5), .cfg_ch(ch5),
        .cfg_mode(mode5), .cfg_period(per5), .cfg_duty(duty5),
        .sync(sync), .tick(tick5), .led(led5)
    );

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] per;
        logic [7:0] duty;
        logic       sy;
        int         cyc;
        logic [3:0] led_pwm;
        logic [3:0] led_nopwm;
        logic       tk;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [1:0] mode,
                                input logic [7:0] per, input logic [7:0] duty, input logic sy,
                                input int cyc, input logic [3:0] lp, input logic [3:0] ln,
                                input logic tk);
        vec_t v;
        v.we = we; v.ch = ch; v.mode = mode; v.per = per; v.duty = duty; v.sy = sy;
        v.cyc = cyc; v.led_pwm = lp; v.led_nopwm = ln; v.tk = tk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then idle until cyc edges have passed.
    task automatic run(input logic we, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [7:0] per, input logic [7:0] duty, input logic sy,
                       input int cyc);
        cfg_we = we; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
        sync = sy;
        @(posedge clk); #1;
        cfg_we = 1'b0; sync = 1'b0;
        repeat (cyc - 1) begin @(posedge clk); #1; end
    endtask

    task automatic w5(input logic [2:0] ch, input logic [1:0] mode);
        we5 = 1'b1; ch5 = ch; mode5 = mode;
        @(posedge clk); #1;
        we5 = 1'b0;
    endtask

    initial begin
        int  first, last, nt;
        bit  bad_gap, led_nz;
        logic [3:0] e;

        // Relative to write+sync at edge k (BLINK P=3 on ch0), then s/s2/s3/s4.
        tbl[0]  = mk(1, 0, 2, 3, 0, 1, 1,  4'b0000, 4'b0000, 0); // k
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 4,  4'b0000, 4'b0000, 1); // k+4
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 8,  4'b0000, 4'b0000, 1); // k+12
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1,  4'b0001, 4'b0001, 0); // k+13 first toggle
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 11, 4'b0001, 4'b0001, 1); // k+24
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1,  4'b0000, 4'b0000, 0); // k+25 12 cycles high
        tbl[6]  = mk(1, 1, 1, 0, 0, 0, 1,  4'b0010, 4'b0010, 0); // ch1 ON
        tbl[7]  = mk(1, 2, 3, 4, 1, 1, 1,  4'b0110, 4'b0010, 0); // s: ch2 PWM P4 d1
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 4,  4'b0110, 4'b0010, 1); // s+4
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1,  4'b0010, 4'b0010, 0); // s+5
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 8,  4'b0011, 4'b0011, 0); // s+13
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 4,  4'b0111, 4'b0011, 0); // s+17 PWM wraps
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 3,  4'b0111, 4'b0011, 1); // s+20
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 1,  4'b0011, 4'b0011, 0); // s+21 4 of 16
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 4,  4'b0010, 4'b0010, 0); // s+25
        tbl[15] = mk(1, 2, 3, 4, 0, 1, 1,  4'b0010, 4'b0010, 0); // s2: duty 0
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 20, 4'b0011, 4'b0011, 1); // s2+20
        tbl[17] = mk(1, 2, 3, 4, 9, 1, 1,  4'b0110, 4'b0010, 0); // s3: duty 9
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 17, 4'b0111, 4'b0011, 0); // s3+17
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 6,  4'b0111, 4'b0011, 0); // s3+23
        tbl[20] = mk(1, 2, 3, 4, 3, 1, 1,  4'b0110, 4'b0010, 0); // s4: duty 3
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 9,  4'b0110, 4'b0010, 0); // s4+9 cnt 2 < 3

        // Reset state, then idle with tick period check.
        #12;
        chk("reset_led", led, 4'b0000);
        chk("reset_tick", tick, 1'b0);
        chk("reset_led5", led5, 5'b00000);
        #10 rst_n = 1'b1;
        first = -1; last = -1; nt = 0; bad_gap = 0; led_nz = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (led != 4'b0000) led_nz = 1;
            if (tick) begin
                if (first < 0) first = c;
                else if (c - last != 4) bad_gap = 1;
                last = c;
                nt++;
            end
        end
        chk("idle_led", led_nz, 0);
        chk("first_tick", first, 4);
        chk("tick_count", nt, 25);
        chk("tick_gap", bad_gap, 0);

        for (int i = 0; i < 22; i++) begin
            run(tbl[i].we, tbl[i].ch, tbl[i].mode, tbl[i].per, tbl[i].duty, tbl[i].sy, tbl[i].cyc);
`ifdef BLINK_ARRAY_PWM_EN
            e = tbl[i].led_pwm;
`else
            e = tbl[i].led_nopwm;
`endif
            chk($sformatf("vec%0d_led", i), led, e);
            chk($sformatf("vec%0d_tick", i), tick, tbl[i].tk);
        end

        // Out-of-range channel writes on the 5-channel instance.
        w5(3'd4, 2'd1);
        chk("ch4_on", led5, 5'b10000);
        w5(3'd5, 2'd0);
        chk("ch5_ignored", led5, 5'b10000);
        w5(3'd6, 2'd1);
        chk("ch6_ignored", led5, 5'b10000);
        w5(3'd7, 2'd1);
        chk("ch7_ignored", led5, 5'b10000);
        w5(3'd4, 2'd0);
        chk("ch4_off", led5, 5'b00000);

        // Offset BLINK P=2 on ch0/ch3, then sync realigns them (edge a = phase ref).
        run(1, 2, 0, 0, 0, 1, 1);          // a: ch2 OFF + sync
        chk("sq_a", led, 4'b0010);
        run(1, 0, 2, 2, 0, 0, 8);          // ch0 BLINK at a+1, sample a+8
        run(1, 3, 2, 2, 0, 0, 2);          // ch3 BLINK at a+9 (tick cycle), sample a+10
        chk("sq_before_sync", led, 4'b0011);
        run(0, 0, 0, 0, 0, 1, 1);          // q = a+11
        chk("sq_sync_led", led, 4'b0010);
        chk("sq_sync_tick", tick, 1'b0);
        run(0, 0, 0, 0, 0, 0, 1);
        chk("sq_q1_tick", tick, 1'b0);
        run(0, 0, 0, 0, 0, 0, 2);
        chk("sq_q3_tick", tick, 1'b0);
        run(0, 0, 0, 0, 0, 0, 1);
        chk("sq_q4_tick", tick, 1'b1);
        run(0, 0, 0, 0, 0, 0, 4);
        chk("sq_q8_led", led, 4'b0010);
        run(0, 0, 0, 0, 0, 0, 1);
        chk("sq_q9_led", led, 4'b1011);
        run(0, 0, 0, 0, 0, 0, 7);
        chk("sq_q16_led", led, 4'b1011);
        run(0, 0, 0, 0, 0, 0, 1);
        chk("sq_q17_led", led, 4'b0010);
        run(0, 0, 0, 0, 0, 0, 8);
        chk("sq_q25_led", led, 4'b1011);

        // Asynchronous reset between edges, mid-blink.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", led, 4'b0000);
        chk("async_rst_tick", tick, 1'b0);
        #13 rst_n = 1'b1;
        led_nz = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (led != 4'b0000) led_nz = 1;
        end
        chk("post_rst_all_off", led_nz, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
